// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sequencer sharing one I2C master controller
// between NUM_REQ clients, one single-byte transaction at a time.
module i2c_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tx_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_done,
  output logic [DATA_WIDTH-1:0]           rsp_rx_data,
  output logic                            rsp_ack_error,
  output logic                            rsp_timeout,
  output logic                            ctl_ready,
  output logic                            ctl_rw,
  output logic [ADDR_WIDTH-1:0]           ctl_slave_addr,
  output logic [DATA_WIDTH-1:0]           ctl_tx_data,
  input  logic                            ctl_busy,
  input  logic                            ctl_valid,
  input  logic                            ctl_ack_error,
  input  logic [DATA_WIDTH-1:0]           ctl_rx_data,
  output logic                            active,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;

  state_t                state, state_nx;
  logic [GW-1:0]         ptr;
  logic [GW-1:0]         win;
  logic [GW-1:0]         idx;
  logic                  found;
  logic [TW-1:0]         tcnt;
  logic                  to_hit;
  logic [DATA_WIDTH-1:0] rx_cap;
  logic                  ack_cap;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  ack_next;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign to_hit = (tcnt == TW'(START_TIMEOUT - 1));

  // Round-robin search: first pending client at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 32'(NUM_REQ); k++) begin
      idx = GW'((32'(ptr) + k) % 32'(NUM_REQ));
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Status that will be reported if the controller finishes this cycle;
  // lets a ctl_valid/ack coinciding with busy falling still be seen.
  always_comb begin
    rx_next  = ctl_valid ? ctl_rx_data : rx_cap;
    ack_next = ack_cap | ctl_ack_error;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (found) state_nx = ISSUE;
      ISSUE: begin
        if (ctl_busy)    state_nx = WAIT_DONE;
        else if (to_hit) state_nx = COMPLETE;
      end
      WAIT_DONE: if (!ctl_busy) state_nx = COMPLETE;
      COMPLETE:  state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Registered command, status capture and client-facing outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready      <= '0;
      rsp_done       <= '0;
      rsp_rx_data    <= '0;
      rsp_ack_error  <= 1'b0;
      rsp_timeout    <= 1'b0;
      ctl_ready      <= 1'b0;
      ctl_rw         <= 1'b0;
      ctl_slave_addr <= '0;
      ctl_tx_data    <= '0;
      active         <= 1'b0;
      grant_id       <= '0;
      ptr            <= '0;
      tcnt           <= '0;
      rx_cap         <= '0;
      ack_cap        <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_done  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ctl_rw         <= req_rw[win];
            ctl_slave_addr <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            ctl_tx_data    <= req_tx_data[win*DATA_WIDTH +: DATA_WIDTH];
            grant_id       <= win;
            req_ready      <= onehot(win);
            ptr            <= (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
            rx_cap         <= '0;
            ack_cap        <= 1'b0;
            tcnt           <= '0;
            ctl_ready      <= 1'b1;
            active         <= 1'b1;
          end
        end
        ISSUE: begin
          if (ctl_busy) begin
            ctl_ready <= 1'b0;
          end else if (to_hit) begin
            ctl_ready     <= 1'b0;
            rsp_done      <= onehot(grant_id);
            rsp_rx_data   <= '0;
            rsp_ack_error <= 1'b0;
            rsp_timeout   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          rx_cap  <= rx_next;
          ack_cap <= ack_next;
          if (!ctl_busy) begin
            rsp_done      <= onehot(grant_id);
            rsp_rx_data   <= ctl_rw ? rx_next : '0;
            rsp_ack_error <= ack_next;
            rsp_timeout   <= 1'b0;
          end
        end
        COMPLETE: begin
          active        <= 1'b0;
          rsp_rx_data   <= '0;
          rsp_ack_error <= 1'b0;
          rsp_timeout   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: directed transactions against a small
// controller model; responses checked by a scoreboard monitor.
module tb_i2c_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_rw = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_tx_data = '0;
  logic [3:0]  req_ready, rsp_done;
  logic [7:0]  rsp_rx_data;
  logic        rsp_ack_error, rsp_timeout;
  logic        ctl_ready, ctl_rw;
  logic [6:0]  ctl_slave_addr;
  logic [7:0]  ctl_tx_data;
  logic        ctl_busy = 1'b0, ctl_valid = 1'b0, ctl_ack_error = 1'b0;
  logic [7:0]  ctl_rx_data = '0;
  logic        active;
  logic [1:0]  grant_id;

  i2c_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(7), .DATA_WIDTH(8), .START_TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_tx_data(req_tx_data), .req_ready(req_ready),
    .rsp_done(rsp_done), .rsp_rx_data(rsp_rx_data),
    .rsp_ack_error(rsp_ack_error), .rsp_timeout(rsp_timeout),
    .ctl_ready(ctl_ready), .ctl_rw(ctl_rw), .ctl_slave_addr(ctl_slave_addr),
    .ctl_tx_data(ctl_tx_data), .ctl_busy(ctl_busy), .ctl_valid(ctl_valid),
    .ctl_ack_error(ctl_ack_error), .ctl_rx_data(ctl_rx_data),
    .active(active), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] rx;
    logic       ack;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Controller model behaviour for the current transaction.
  int         m_busy_len = 8;
  logic       m_nack = 1'b0;
  logic       m_hang = 1'b0;
  logic [7:0] m_rd = 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Controller model: goes busy the cycle after seeing ctl_ready, returns
  // a byte with ctl_valid on the last busy cycle, optional mid-busy NACK.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (reset && ctl_ready && !ctl_busy && !m_hang) begin
        ctl_busy = 1'b1;
        for (int c = 0; c < m_busy_len; c++) begin
          if (c == m_busy_len / 2) ctl_ack_error = m_nack;
          if (c == m_busy_len - 1) begin
            ctl_valid   = 1'b1;
            ctl_rx_data = m_rd;
          end
          @(posedge clock); #1;
          ctl_ack_error = 1'b0;
          ctl_valid     = 1'b0;
          if (!reset) break;
        end
        ctl_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every rsp_done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rsp_done != 4'b0000) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp_done: got 0x%0h, expected none", rsp_done);
        end else begin
          e = sb.pop_front();
          check("rsp_done",      32'(rsp_done),      32'(4'b0001 << e.id));
          check("rsp_rx_data",   32'(rsp_rx_data),   32'(e.rx));
          check("rsp_ack_error", 32'(rsp_ack_error), 32'(e.ack));
          check("rsp_timeout",   32'(rsp_timeout),   32'(e.to));
        end
      end
    end
  end

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  // Single request from an otherwise idle client set; checks accept-cycle
  // command outputs and queues the expected response.
  task automatic do_req(input int id, input logic rw, input logic [6:0] addr,
                        input logic [7:0] data, input logic nack, input int blen);
    m_busy_len = blen;
    m_nack     = nack;
    m_hang     = 1'b0;
    req_rw[id]             = rw;
    req_addr[id*7 +: 7]    = addr;
    req_tx_data[id*8 +: 8] = data;
    req_valid[id]          = 1'b1;
    sb.push_back('{id: 2'(id), rx: (rw ? m_rd : 8'h00), ack: nack, to: 1'b0});
    @(negedge clock);
    check("req_ready",      32'(req_ready),      32'(4'b0001 << id));
    check("ctl_ready",      32'(ctl_ready),      32'd1);
    check("active",         32'(active),         32'd1);
    check("grant_id",       32'(grant_id),       32'(id));
    check("ctl_rw",         32'(ctl_rw),         32'(rw));
    check("ctl_slave_addr", 32'(ctl_slave_addr), 32'(addr));
    check("ctl_tx_data",    32'(ctl_tx_data),    32'(data));
    req_valid[id] = 1'b0;
    @(negedge clock);
    check("req_ready_pulse", 32'(req_ready), 32'd0);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int guard;
    int cnt;
    logic saw_idle;

    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_done",  32'(rsp_done),  32'd0);
    check("rst_ctl_ready", 32'(ctl_ready), 32'd0);
    check("rst_active",    32'(active),    32'd0);
    check("rst_grant_id",  32'(grant_id),  32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Fairness: all clients continuously requesting; ptr starts at 0.
    m_busy_len = 4;
    m_nack     = 1'b0;
    m_hang     = 1'b0;
    m_rd       = 8'h77;
    for (int i = 0; i < 4; i++) begin
      req_rw[i]             = i[0];
      req_addr[i*7 +: 7]    = 7'(7'h10 + i);
      req_tx_data[i*8 +: 8] = 8'(8'h80 + i);
    end
    for (int k = 0; k < 8; k++)
      sb.push_back('{id: 2'(k % 4), rx: (((k % 4) & 1) != 0 ? 8'h77 : 8'h00), ack: 1'b0, to: 1'b0});
    req_valid = 4'b1111;
    grants    = 0;
    guard     = 0;
    saw_idle  = 1'b1;
    while (grants < 8 && guard < 400) begin
      @(negedge clock);
      guard++;
      if (!active) saw_idle = 1'b1;
      if (req_ready != 4'b0000) begin
        check("fair_grant", 32'(grant_id),  32'(grants % 4));
        check("fair_ready", 32'(req_ready), 32'(4'b0001 << (grants % 4)));
        check("fair_gap",   32'(saw_idle),  32'd1);
        saw_idle = 1'b0;
        grants++;
        if (grants == 8) req_valid = 4'b0000;
      end
    end
    check("fair_count", 32'(grants), 32'd8);
    wait_drain();

    // Single write, long busy window.
    m_rd = 8'hEE;
    do_req(2, 1'b0, 7'h50, 8'hA5, 1'b0, 40);

    // Read returning 0x3C.
    m_rd = 8'h3C;
    do_req(0, 1'b1, 7'h21, 8'h00, 1'b0, 10);

    // NACK, then flag must be clear on the following transaction.
    m_rd = 8'hEE;
    do_req(1, 1'b0, 7'h33, 8'h11, 1'b1, 12);
    m_rd = 8'h5A;
    do_req(1, 1'b1, 7'h33, 8'h00, 1'b0, 6);

    // Timeout: controller never goes busy.
    m_hang = 1'b1;
    req_rw[3]          = 1'b1;
    req_addr[21 +: 7]  = 7'h7F;
    req_tx_data[24 +: 8] = 8'h00;
    req_valid[3]       = 1'b1;
    sb.push_back('{id: 2'd3, rx: 8'h00, ack: 1'b0, to: 1'b1});
    @(negedge clock);
    check("to_req_ready", 32'(req_ready), 32'b1000);
    req_valid[3] = 1'b0;
    cnt   = 0;
    guard = 0;
    while (ctl_ready && guard < 40) begin
      cnt++;
      guard++;
      @(negedge clock);
    end
    check("to_ready_cycles", 32'(cnt), 32'd16);
    check("to_done_timing",  32'(rsp_done), 32'b1000);
    wait_drain();
    m_hang = 1'b0;

    // Reset during WAIT_DONE: transaction dropped, no rsp_done.
    m_busy_len = 40;
    m_nack     = 1'b0;
    req_rw[2]            = 1'b0;
    req_addr[14 +: 7]    = 7'h44;
    req_tx_data[16 +: 8] = 8'h99;
    req_valid[2]         = 1'b1;
    @(negedge clock);
    check("rw_req_ready", 32'(req_ready), 32'b0100);
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clock);
    check("rw_in_wait", 32'({active, ctl_ready}), 32'b10);
    reset = 1'b0;
    #1;
    check("rst_mid_grant_id", 32'(grant_id),       32'd0);
    check("rst_mid_addr",     32'(ctl_slave_addr), 32'd0);
    check("rst_mid_data",     32'(ctl_tx_data),    32'd0);
    check("rst_mid_active",   32'(active),         32'd0);
    check("rst_mid_status",   32'({rsp_done, rsp_rx_data, rsp_ack_error, rsp_timeout, ctl_ready, ctl_rw, req_ready}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    m_rd = 8'hEE;
    do_req(3, 1'b0, 7'h2A, 8'hC3, 1'b0, 6);

    repeat (5) @(negedge clock);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
